// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared constants and helpers for the mmu_8722 block
package mmu_pkg;

  localparam logic [7:0] VERSION_DEFAULT = 8'h20;

  localparam logic [7:0] OFF_CR   = 8'h00;
  localparam logic [7:0] OFF_PCRA = 8'h01;
  localparam logic [7:0] OFF_PCRB = 8'h02;
  localparam logic [7:0] OFF_PCRC = 8'h03;
  localparam logic [7:0] OFF_PCRD = 8'h04;
  localparam logic [7:0] OFF_MCR  = 8'h05;
  localparam logic [7:0] OFF_RCR  = 8'h06;
  localparam logic [7:0] OFF_P0L  = 8'h07;
  localparam logic [7:0] OFF_P0H  = 8'h08;
  localparam logic [7:0] OFF_P1L  = 8'h09;
  localparam logic [7:0] OFF_P1H  = 8'h0A;
  localparam logic [7:0] OFF_VR   = 8'h0B;

  localparam logic [7:0] PAGE_D5  = 8'hD5;
  localparam logic [7:0] PAGE_FF  = 8'hFF;
  localparam logic [7:0] FF_LAST  = 8'h04;

  // CR bit fields
  localparam int CR_IO_SEL  = 0;
  localparam int CR_BANK_LO = 6;
  localparam int CR_BANK_HI = 7;

  // MCR bits that are actually stored
  localparam int MCR_Z80 = 0;
  localparam int MCR_C64 = 6;

  // Shared RAM window size selected by RCR[1:0]; 17 bits so the top bound fits
  function automatic logic [16:0] shared_size(input logic [1:0] sel);
    case (sel)
      2'd0:    shared_size = 17'h00400;
      2'd1:    shared_size = 17'h01000;
      2'd2:    shared_size = 17'h02000;
      default: shared_size = 17'h04000;
    endcase
  endfunction

endpackage

// File: rtl/mmu_page_xlate.sv
// rtl/mmu_page_xlate.sv - page relocation and shared-RAM bank override
module mmu_page_xlate
  import mmu_pkg::*;
(
  input  logic        aec_i,
  input  logic        ms3_i,
  input  logic [15:0] addr_i,
  input  logic [1:0]  cr_bank_i,
  input  logic [7:0]  p0l_i,
  input  logic [1:0]  p0h_bank_i,
  input  logic [7:0]  p1l_i,
  input  logic [1:0]  p1h_bank_i,
  input  logic [1:0]  rcr_bank_i,
  input  logic [3:0]  rcr_shared_i,
  output logic [7:0]  ta_o,
  output logic [1:0]  ram_bank_o
);

  logic [7:0]  page;
  logic [16:0] size;
  logic        shared_hit;

  assign page = addr_i[15:8];
  assign size = shared_size(rcr_shared_i[1:0]);

  assign shared_hit = (rcr_shared_i[2] && ({1'b0, addr_i} < size)) ||
                      (rcr_shared_i[3] && ({1'b0, addr_i} >= (17'h10000 - size)));

  always_comb begin
    ta_o       = page;
    ram_bank_o = cr_bank_i;
    if (!aec_i) begin
      ram_bank_o = rcr_bank_i;
    end else if (!ms3_i) begin
      ram_bank_o = 2'b00;
    end else begin
      // Pages 0/1 and their relocation targets swap places
      if (page == 8'h00) begin
        ta_o       = p0l_i;
        ram_bank_o = p0h_bank_i;
      end else if (page == 8'h01) begin
        ta_o       = p1l_i;
        ram_bank_o = p1h_bank_i;
      end else if (page == p0l_i && cr_bank_i == p0h_bank_i) begin
        ta_o = 8'h00;
      end else if (page == p1l_i && cr_bank_i == p1h_bank_i) begin
        ta_o = 8'h01;
      end
      if (shared_hit) begin
        ram_bank_o = 2'b00;
      end
    end
  end

endmodule

// File: rtl/mmu_8722.sv
// rtl/mmu_8722.sv - C128 MMU: register file, address decode and PLA mode selects
module mmu_8722
  import mmu_pkg::*;
#(
  parameter logic [7:0] VERSION = VERSION_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc,
  input  logic        aec,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_en,
  input  logic        game,
  input  logic        exrom,
  input  logic        key4080,
  output logic        ms0,
  output logic        ms1,
  output logic        ms2,
  output logic        ms3,
  output logic        z80en,
  output logic [7:0]  ta,
  output logic [1:0]  ram_bank
);

  logic [7:0]       cr_q, cr_d;
  logic [3:0][7:0]  pcr_q, pcr_d;
  logic             mcr_c64_q, mcr_c64_d;
  logic             mcr_z80_q, mcr_z80_d;
  logic [7:0]       rcr_q, rcr_d;
  logic [7:0]       p0l_q, p0l_d, p0h_q, p0h_d, p0h_p_q, p0h_p_d;
  logic [7:0]       p1l_q, p1l_d, p1h_q, p1h_d, p1h_p_q, p1h_p_d;

  logic d5_hit, ff_hit, wr_en, rd_en;

  assign ms3   = !mcr_c64_q;
  assign z80en = !mcr_z80_q;
  assign ms2   = cr_q[CR_IO_SEL];

  assign d5_hit = (addr[15:8] == PAGE_D5) && !cr_q[CR_IO_SEL] && ms3;
  assign ff_hit = (addr[15:8] == PAGE_FF) && (addr[7:0] <= FF_LAST) && ms3;
  assign wr_en  = cyc && aec && !rw;
  assign rd_en  = aec && rw;

  always_ff @(posedge clk) begin
    if (reset) begin
      cr_q      <= 8'h00;
      pcr_q     <= '0;
      mcr_c64_q <= 1'b0;
      mcr_z80_q <= 1'b0;
      rcr_q     <= 8'h00;
      p0l_q     <= 8'h00;
      p0h_q     <= 8'h00;
      p0h_p_q   <= 8'h00;
      p1l_q     <= 8'h01;
      p1h_q     <= 8'h00;
      p1h_p_q   <= 8'h00;
    end else begin
      cr_q      <= cr_d;
      pcr_q     <= pcr_d;
      mcr_c64_q <= mcr_c64_d;
      mcr_z80_q <= mcr_z80_d;
      rcr_q     <= rcr_d;
      p0l_q     <= p0l_d;
      p0h_q     <= p0h_d;
      p0h_p_q   <= p0h_p_d;
      p1l_q     <= p1l_d;
      p1h_q     <= p1h_d;
      p1h_p_q   <= p1h_p_d;
    end
  end

  always_comb begin
    cr_d      = cr_q;
    pcr_d     = pcr_q;
    mcr_c64_d = mcr_c64_q;
    mcr_z80_d = mcr_z80_q;
    rcr_d     = rcr_q;
    p0l_d     = p0l_q;
    p0h_d     = p0h_q;
    p0h_p_d   = p0h_p_q;
    p1l_d     = p1l_q;
    p1h_d     = p1h_q;
    p1h_p_d   = p1h_p_q;
    if (wr_en && d5_hit) begin
      case (addr[7:0])
        OFF_CR:   cr_d     = din;
        OFF_PCRA: pcr_d[0] = din;
        OFF_PCRB: pcr_d[1] = din;
        OFF_PCRC: pcr_d[2] = din;
        OFF_PCRD: pcr_d[3] = din;
        OFF_MCR: begin
          mcr_c64_d = din[MCR_C64];
          mcr_z80_d = din[MCR_Z80];
        end
        OFF_RCR:  rcr_d    = din;
        // High pointer bytes only take effect when the low byte is written
        OFF_P0L: begin
          p0l_d = din;
          p0h_d = p0h_p_q;
        end
        OFF_P0H:  p0h_p_d  = din;
        OFF_P1L: begin
          p1l_d = din;
          p1h_d = p1h_p_q;
        end
        OFF_P1H:  p1h_p_d  = din;
        default: ;
      endcase
    end else if (wr_en && ff_hit) begin
      // FF01-FF04 load CR from a pre-configuration; their data byte is dropped
      case (addr[2:0])
        3'd0:    cr_d = din;
        3'd1:    cr_d = pcr_q[0];
        3'd2:    cr_d = pcr_q[1];
        3'd3:    cr_d = pcr_q[2];
        3'd4:    cr_d = pcr_q[3];
        default: ;
      endcase
    end
  end

  always_comb begin
    dout    = 8'hFF;
    dout_en = 1'b0;
    if (rd_en && d5_hit) begin
      dout_en = 1'b1;
      case (addr[7:0])
        OFF_CR:   dout = cr_q;
        OFF_PCRA: dout = pcr_q[0];
        OFF_PCRB: dout = pcr_q[1];
        OFF_PCRC: dout = pcr_q[2];
        OFF_PCRD: dout = pcr_q[3];
        OFF_MCR:  dout = {key4080, mcr_c64_q, exrom, game, 3'b111, mcr_z80_q};
        OFF_RCR:  dout = rcr_q;
        OFF_P0L:  dout = p0l_q;
        OFF_P0H:  dout = p0h_q;
        OFF_P1L:  dout = p1l_q;
        OFF_P1H:  dout = p1h_q;
        OFF_VR:   dout = VERSION;
        default:  dout = 8'hFF;
      endcase
    end else if (rd_en && ff_hit) begin
      dout_en = 1'b1;
      case (addr[2:0])
        3'd0:    dout = cr_q;
        3'd1:    dout = pcr_q[0];
        3'd2:    dout = pcr_q[1];
        3'd3:    dout = pcr_q[2];
        3'd4:    dout = pcr_q[3];
        default: dout = 8'hFF;
      endcase
    end
  end

  always_comb begin
    {ms1, ms0} = 2'b00;
    case (addr[15:14])
      2'b00: {ms1, ms0} = 2'b00;
      2'b01: {ms1, ms0} = {cr_q[1], cr_q[1]};
      2'b10: {ms1, ms0} = cr_q[3:2];
      2'b11: {ms1, ms0} = cr_q[5:4];
      default: ;
    endcase
  end

  mmu_page_xlate u_xlate (
    .aec_i        (aec),
    .ms3_i        (ms3),
    .addr_i       (addr),
    .cr_bank_i    (cr_q[CR_BANK_HI:CR_BANK_LO]),
    .p0l_i        (p0l_q),
    .p0h_bank_i   (p0h_q[1:0]),
    .p1l_i        (p1l_q),
    .p1h_bank_i   (p1h_q[1:0]),
    .rcr_bank_i   (rcr_q[7:6]),
    .rcr_shared_i (rcr_q[3:0]),
    .ta_o         (ta),
    .ram_bank_o   (ram_bank)
  );

endmodule

// File: doc/mmu_8722.md
Name: mmu_8722

Overview:
Memory management unit that sits directly upstream of the C128 PLA. It holds the CPU-visible configuration, pre-configuration, mode, RAM-config and page-pointer registers. From these and the live CPU address it generates the PLA mode/select inputs (ms0..ms3, z80en), the translated high address ta[15:8] and the RAM bank select. Register writes are synchronous; all decode and translation outputs are combinational from registered state and the current address.

Parameters:
VERSION, 8'h20, value returned by the version register (D50B)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cyc  in  1  one-clk strobe per CPU bus cycle; qualifies register writes
aec  in  1  1 = CPU owns bus, 0 = VIC access
rw  in  1  1 = read, 0 = write
addr  in  16  CPU address
din  in  8  CPU write data
dout  out  8  register read data
dout_en  out  1  1 when a readable MMU register is addressed (aec & rw)
game  in  1  cartridge GAME line, read back in MCR bit4
exrom  in  1  cartridge EXROM line, read back in MCR bit5
key4080  in  1  40/80 key sense, read back in MCR bit7
ms0, ms1, ms2, ms3  out  1 each  mode selects to PLA
z80en  out  1  1 = Z80 active
ta  out  8  translated address bits 15:8
ram_bank  out  2  RAM bank select

Behaviour:
- Registers: CR, PCRA..PCRD, MCR, RCR, P0L, P0H, P1L, P1H, plus pending P0H_p and P1H_p.
- Reset (synchronous, on the clk edge with reset=1): all 0x00, except P1L = 0x01. The Z80 is therefore active after reset (z80en=1), in C128 mode (ms3=1).
- Decode:
  - D5 window: addr[15:8]=D5, CR[0]=0 and ms3=1. Offsets 00..0B map to CR, PCRA-D, MCR, RCR, P0L, P0H, P1L, P1H, VR. Offsets 0C..FF read FF; writes to them are ignored.
  - FF window: ms3=1 and addr FF00..FF04, regardless of CR.
- Write on the clk edge when cyc & aec & !rw & (decode hit):
  - D500/FF00 -> CR.
  - D501-D504 -> PCRA-D.
  - FF01-FF04: the data is discarded; CR <= PCRA-D respectively.
  - D505 -> MCR bits 6,0 only.
  - D506 -> RCR.
  - D508 -> P0H_p. D507 -> P0L, and on the same edge P0H <= P0H_p. P1 pair behaves the same way (D50A pending, D509 commits).
  - VR is read-only.
- Read data (combinational):
  - MCR reads {key4080, MCR[6], exrom, game, 3'b111, MCR[0]}.
  - P0H/P1H read the committed value, not the pending one.
  - FF01-04 read PCRA-D. VR reads VERSION.
- Mode outputs:
  - ms3 = !MCR[6]; z80en = !MCR[0]; ms2 = CR[0].
  - {ms1,ms0}: 0000-3FFF -> 00; 4000-7FFF -> {CR[1],CR[1]}; 8000-BFFF -> CR[3:2]; C000-FFFF -> CR[5:4].
- Translation, in priority order:
  1. !aec: ta=addr[15:8], ram_bank=RCR[7:6].
  2. ms3=0: ta=addr[15:8], ram_bank=0.
  3. Page 00 -> ta=P0L, bank=P0H[1:0].
  4. Page 01 -> ta=P1L, bank=P1H[1:0].
  5. Page==P0L and CR[7:6]==P0H[1:0] -> ta=00. Page==P1L, likewise -> ta=01.
  6. Otherwise ta=page, bank=CR[7:6].
- Shared RAM: size from RCR[1:0] = 1K/4K/8K/16K. If RCR[2] and addr < size, or RCR[3] and addr >= 10000h-size, force ram_bank=0. Applied after translation, only when aec=1 and ms3=1.
- Corner cases:
  - Write without cyc: no effect.
  - Write while aec=0: no effect.
  - Reset mid pointer sequence: pending register cleared.
  - Consecutive P0H writes: the last value wins.
  - P0L written with no prior P0H write: commits the current P0H_p.

Decomposition:
- Shared package mmu_pkg: register offset constants, CR bit-field constants, shared-size table, VERSION default.
- One natural sub-module, mmu_page_xlate: combinational translation and shared-RAM override. Register file and decode stay in mmu_8722.

Test Plan:
- Reset -> CR=00, z80en=1, ms3=1, P1L=01; read D50B -> 20; read D50C -> FF.
- Write D501=3E, then write FF01=xx -> CR=3E, D500 reads 3E; addr C123 gives {ms1,ms0}=11, ms2=0.
- Write D508=01 -> read D508 still 00, page 00 maps ta=00; write D507=20 -> addr 0045 gives ta=20, bank 1; addr 2045 with CR[7:6]=01 gives ta=00.
- RCR=05 (bottom, 4K), CR=40 -> addr 0F00 forces ram_bank=0; addr 1000 gives ram_bank=1.
- Write D505=41 -> ms3=0, z80en=0; a D500 write is now ignored and FF00 reads are not decoded (dout_en=0).
- aec=0, RCR=C0 -> ram_bank=3, ta=addr[15:8]; a write strobe with aec=0 leaves all registers unchanged.
